// File: rtl/alu_mc_if.sv
// Request/result channel of the multi-cycle ALU.
// The master drives operands and consumes results; the ALU is the slave.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic             aluSrc;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] imm;
    logic [3:0]       aluCtrl;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output inValid, aluSrc, data1, data2, imm, aluCtrl, outReady,
        input  inReady, outValid, result, zero, overflow
    );

    modport slave (
        input  inValid, aluSrc, data1, data2, imm, aluCtrl, outReady,
        output inReady, outValid, result, zero, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
// The result register only changes when a new result is produced, so the
// outputs stay stable while the consumer stalls.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rstN,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     opA_q, opA_d;
    logic [WIDTH-1:0]     opB_q, opB_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     opBIn;
    logic [SHW-1:0]       shAmt;
    logic [WIDTH:0]       addSum;
    logic [WIDTH-1:0]     quickRes;
    logic                 quickOvf;
    logic                 isIterIn;

    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       divShift;
    logic                 divGe;
    logic [WIDTH-1:0]     divDiff;
    logic [2*WIDTH-1:0]   divNext;
    logic [2*WIDTH-1:0]   stepNext;
    logic [WIDTH-1:0]     iterRes;
    logic                 iterOvf;

    // Single-cycle result and flag computed from the operands being offered.
    always_comb begin : quickAlu
        opBIn    = bus.aluSrc ? bus.imm : bus.data2;
        shAmt    = opBIn[SHW-1:0];
        addSum   = {1'b0, bus.data1} + {1'b0, opBIn};
        isIterIn = (bus.aluCtrl[3:2] == 2'b11);
        quickRes = '0;
        quickOvf = 1'b0;
        case (bus.aluCtrl)
            4'b0000: begin
                quickRes = addSum[WIDTH-1:0];
                quickOvf = addSum[WIDTH];
            end
            4'b0010: begin
                quickRes = bus.data1 - opBIn;
                quickOvf = (bus.data1 < opBIn);
            end
            4'b0100: quickRes = bus.data1 & opBIn;
            4'b0101: quickRes = bus.data1 | opBIn;
            4'b0110: quickRes = bus.data1 << shAmt;
            4'b0111: quickRes = bus.data1 >> shAmt;
            4'b1000: quickRes = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(opBIn))};
            4'b1001: quickRes = {{(WIDTH-1){1'b0}}, (bus.data1 == opBIn)};
            4'b1010: quickRes = {{(WIDTH-1){1'b0}}, (bus.data1 != opBIn)};
            4'b1011: quickRes = $unsigned($signed(bus.data1) >>> shAmt);
            default: quickRes = '0;
        endcase
    end

    // One multiply or divide iteration on the shared accumulator {hi, lo}.
    always_comb begin : iterStep
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opA_q} : '0);
        mulNext  = {mulSum, acc_q[WIDTH-1:1]};
        divShift = acc_q[2*WIDTH-1:WIDTH-1];
        divGe    = (divShift >= {1'b0, opB_q});
        divDiff  = divShift[WIDTH-1:0] - opB_q;
        divNext  = divGe ? {divDiff, acc_q[WIDTH-2:0], 1'b1}
                         : {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        stepNext = op_q[1] ? divNext : mulNext;
        iterRes  = op_q[0] ? stepNext[2*WIDTH-1:WIDTH] : stepNext[WIDTH-1:0];
        iterOvf  = op_q[1] && (opB_q == '0);
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and datapath registers.
    always_comb begin : fsmNext
        state_d  = state_q;
        cnt_d    = cnt_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.inValid) begin
                    opA_d = bus.data1;
                    opB_d = opBIn;
                    op_d  = bus.aluCtrl[1:0];
                    cnt_d = '0;
                    if (isIterIn) begin
                        acc_d   = bus.aluCtrl[1] ? {{WIDTH{1'b0}}, bus.data1}
                                                 : {{WIDTH{1'b0}}, opBIn};
                        state_d = BUSY;
                    end else begin
                        result_d = quickRes;
                        zero_d   = (quickRes == '0);
                        ovf_d    = quickOvf;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                acc_d = stepNext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    result_d = iterRes;
                    zero_d   = (iterRes == '0);
                    ovf_d    = iterOvf;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rstN) begin : fsmRegs
        if (!rstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.inReady  = (state_q == IDLE) && rstN;
    assign bus.outValid = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, randomized ops
// against a behavioural model, backpressure, mid-operation reset and a
// 16-bit instance.
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W))  bus ();
    alu_mc_if #(.WIDTH(16)) bus16 ();

    alu_mc #(.WIDTH(W))  dut   (.clk(clk), .rstN(rstN), .bus(bus));
    alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rstN(rstN), .bus(bus16));

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic        src;
        logic [31:0] a;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] expRes;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passes = 0;

    logic [31:0] gotRes;
    logic        gotZero;
    logic        gotOvf;
    int          gotLat;
    logic        gotBusyOk;

    logic [15:0] got16Res;
    logic        got16Zero;
    logic        got16Ovf;
    int          got16Lat;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic addVec(input string n, input logic [3:0] c, input logic s,
                          input logic [31:0] a, input logic [31:0] d2, input logic [31:0] im,
                          input logic [31:0] r, input logic o);
        vec_t v;
        v.name = n; v.ctrl = c; v.src = s; v.a = a; v.d2 = d2; v.imm = im;
        v.expRes = r; v.expOvf = o;
        vecs.push_back(v);
    endtask

    // Behavioural reference: plain arithmetic on the architectural rules.
    function automatic logic [32:0] refModel(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] sra;
        int          sh;
        sh  = int'(b % 32);
        p   = 64'(a) * 64'(b);
        sra = $signed(a) >>> sh;
        case (c)
            4'd0:  return 33'(a) + 33'(b);
            4'd2:  return {(a < b), a - b};
            4'd4:  return {1'b0, a & b};
            4'd5:  return {1'b0, a | b};
            4'd6:  return {1'b0, a << sh};
            4'd7:  return {1'b0, a >> sh};
            4'd8:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            4'd9:  return {1'b0, 31'd0, (a == b)};
            4'd10: return {1'b0, 31'd0, (a != b)};
            4'd11: return {1'b0, sra};
            4'd12: return {1'b0, p[31:0]};
            4'd13: return {1'b0, p[63:32]};
            4'd14: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            4'd15: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
            default: return 33'd0;
        endcase
    endfunction

    // Issue one request on the 32-bit DUT and wait for its result.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic src, input logic [31:0] a,
                                 input logic [31:0] d2, input logic [31:0] im, input logic hold);
        int guard;
        guard = 0;
        while (bus.inReady !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) timeoutFail("wait_inReady");
        bus.aluCtrl  = ctrl;
        bus.aluSrc   = src;
        bus.data1    = a;
        bus.data2    = d2;
        bus.imm      = im;
        bus.inValid  = 1'b1;
        bus.outReady = !hold;
        gotLat    = 0;
        gotBusyOk = 1'b1;
        do begin
            @(posedge clk); #1; gotLat++;
            bus.inValid = 1'b0;
            bus.data1   = $urandom;
            bus.data2   = $urandom;
            bus.imm     = $urandom;
            bus.aluCtrl = 4'($urandom);
            bus.aluSrc  = 1'($urandom);
            if (bus.outValid !== 1'b1 && bus.inReady !== 1'b0) gotBusyOk = 1'b0;
        end while (bus.outValid !== 1'b1 && gotLat < 100);
        if (gotLat >= 100) timeoutFail("wait_outValid");
        gotRes  = bus.result;
        gotZero = bus.zero;
        gotOvf  = bus.overflow;
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue one request on the 16-bit DUT and wait for its result.
    task automatic apply16(input logic [3:0] ctrl, input logic src, input logic [15:0] a,
                           input logic [15:0] d2, input logic [15:0] im);
        bus16.aluCtrl  = ctrl;
        bus16.aluSrc   = src;
        bus16.data1    = a;
        bus16.data2    = d2;
        bus16.imm      = im;
        bus16.inValid  = 1'b1;
        bus16.outReady = 1'b1;
        got16Lat = 0;
        do begin
            @(posedge clk); #1; got16Lat++;
            bus16.inValid = 1'b0;
        end while (bus16.outValid !== 1'b1 && got16Lat < 100);
        if (got16Lat >= 100) timeoutFail("wait16_outValid");
        got16Res  = bus16.result;
        got16Zero = bus16.zero;
        got16Ovf  = bus16.overflow;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [31:0] a, b, d2, im, holdRes;
        logic [32:0] exp;
        logic [3:0]  c;
        logic        src, seen;
        int          expLat;

        bus.inValid = 1'b0; bus.aluSrc = 1'b0; bus.data1 = '0; bus.data2 = '0;
        bus.imm = '0; bus.aluCtrl = '0; bus.outReady = 1'b1;
        bus16.inValid = 1'b0; bus16.aluSrc = 1'b0; bus16.data1 = '0; bus16.data2 = '0;
        bus16.imm = '0; bus16.aluCtrl = '0; bus16.outReady = 1'b1;

        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        checkOutput("rst_inReady",  32'(bus.inReady),  32'd0);
        checkOutput("rst_outValid", 32'(bus.outValid), 32'd0);
        checkOutput("rst_result",   bus.result,        32'd0);
        checkOutput("rst_zero",     32'(bus.zero),     32'd1);
        checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        checkOutput("rel_inReady", 32'(bus.inReady), 32'd1);

        // Directed vectors with hand-derived expectations.
        addVec("add_3_5",     4'b0000, 1'b0, 32'd3,          32'd5,          32'd0,  32'd8,          1'b0);
        addVec("add_imm",     4'b0000, 1'b1, 32'd7,          32'd1234,       32'd9,  32'd16,         1'b0);
        addVec("add_carry",   4'b0000, 1'b0, 32'hFFAA123E,   32'hDD1111B1,   32'd0,  32'hDCBB23EF,   1'b1);
        addVec("sub_eq",      4'b0010, 1'b0, 32'd5,          32'd5,          32'd0,  32'd0,          1'b0);
        addVec("sub_borrow",  4'b0010, 1'b1, 32'd3,          32'd0,          32'd5,  32'hFFFFFFFE,   1'b1);
        addVec("and",         4'b0100, 1'b0, 32'hF0F0,       32'hFF00,       32'd0,  32'hF000,       1'b0);
        addVec("or",          4'b0101, 1'b0, 32'hF0F0,       32'hFF00,       32'd0,  32'hFFF0,       1'b0);
        addVec("sll_31",      4'b0110, 1'b0, 32'd1,          32'd31,         32'd0,  32'h80000000,   1'b0);
        addVec("sll_wrap",    4'b0110, 1'b0, 32'd1,          32'd33,         32'd0,  32'd2,          1'b0);
        addVec("srl",         4'b0111, 1'b0, 32'h80000000,   32'd31,         32'd0,  32'd1,          1'b0);
        addVec("sra",         4'b1011, 1'b1, 32'h80000000,   32'd0,          32'd4,  32'hF8000000,   1'b0);
        addVec("slt_neg",     4'b1000, 1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,  32'd1,          1'b0);
        addVec("beq",         4'b1001, 1'b0, 32'd7,          32'd7,          32'd0,  32'd1,          1'b0);
        addVec("bne",         4'b1010, 1'b0, 32'd10,         32'd20,         32'd0,  32'd1,          1'b0);
        addVec("op0001",      4'b0001, 1'b0, 32'd10,         32'd20,         32'd0,  32'd0,          1'b0);
        addVec("op0011",      4'b0011, 1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,  32'd0,          1'b0);
        addVec("mul",         4'b1100, 1'b0, 32'h10000,      32'h30000,      32'd0,  32'd0,          1'b0);
        addVec("mulhu",       4'b1101, 1'b0, 32'h10000,      32'h30000,      32'd0,  32'd3,          1'b0);
        addVec("divu",        4'b1110, 1'b0, 32'd100,        32'd7,          32'd0,  32'd14,         1'b0);
        addVec("remu",        4'b1111, 1'b1, 32'd100,        32'd0,          32'd7,  32'd2,          1'b0);
        addVec("divu_zero",   4'b1110, 1'b0, 32'd100,        32'd0,          32'd0,  32'hFFFFFFFF,   1'b1);
        addVec("remu_zero",   4'b1111, 1'b0, 32'd100,        32'd0,          32'd0,  32'd100,        1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ctrl, vecs[i].src, vecs[i].a, vecs[i].d2, vecs[i].imm, 1'b0);
            expLat = (vecs[i].ctrl[3:2] == 2'b11) ? W + 1 : 1;
            checkOutput({vecs[i].name, "_res"},  gotRes,          vecs[i].expRes);
            checkOutput({vecs[i].name, "_ovf"},  32'(gotOvf),     32'(vecs[i].expOvf));
            checkOutput({vecs[i].name, "_zero"}, 32'(gotZero),    32'(vecs[i].expRes == 32'd0));
            checkOutput({vecs[i].name, "_lat"},  32'(gotLat),     32'(expLat));
            if (vecs[i].ctrl[3:2] == 2'b11)
                checkOutput({vecs[i].name, "_busy_inReady"}, 32'(gotBusyOk), 32'd1);
        end

        // Randomized operations against the reference model.
        for (int n = 0; n < 48; n++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 2);
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            src = 1'($urandom);
            d2  = src ? $urandom : b;
            im  = src ? b : $urandom;
            exp = refModel(c, a, b);
            applyStimulus(c, src, a, d2, im, 1'b0);
            checkOutput($sformatf("rnd%0d_op%0d_res", n, c), gotRes, exp[31:0]);
            checkOutput($sformatf("rnd%0d_op%0d_ovf", n, c), 32'(gotOvf), 32'(exp[32]));
            checkOutput($sformatf("rnd%0d_op%0d_zero", n, c), 32'(gotZero), 32'(exp[31:0] == 32'd0));
            checkOutput($sformatf("rnd%0d_op%0d_lat", n, c), 32'(gotLat), 32'((c[3:2] == 2'b11) ? W + 1 : 1));
        end

        // Backpressure: result held while outReady=0, new request ignored.
        applyStimulus(4'b1100, 1'b0, 32'h1234, 32'h10, 32'd0, 1'b1);
        checkOutput("bp_res", gotRes, 32'h12340);
        holdRes = gotRes;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                bus.aluCtrl = 4'b0000; bus.aluSrc = 1'b0;
                bus.data1 = 32'd1; bus.data2 = 32'd1; bus.inValid = 1'b1;
            end else begin
                bus.inValid = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold%0d_res", k), bus.result, holdRes);
            checkOutput($sformatf("bp_hold%0d_flags", k), {30'd0, bus.outValid, bus.inReady}, 32'd2);
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_outValid", 32'(bus.outValid), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.outValid !== 1'b0) seen = 1'b1;
        end
        checkOutput("bp_not_queued", 32'(seen), 32'd0);
        checkOutput("idle_res_stable", bus.result, holdRes);

        // Reset in the middle of a divide discards it.
        bus.aluCtrl = 4'b1110; bus.aluSrc = 1'b0;
        bus.data1 = 32'd100; bus.data2 = 32'd7; bus.inValid = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("div_busy_inReady", 32'(bus.inReady), 32'd0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midrst_outValid", 32'(bus.outValid), 32'd0);
        checkOutput("midrst_inReady",  32'(bus.inReady),  32'd0);
        checkOutput("midrst_result",   bus.result,        32'd0);
        checkOutput("midrst_zero",     32'(bus.zero),     32'd1);
        @(posedge clk); #1;
        rstN = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < W + 5; k++) begin
            @(posedge clk); #1;
            if (bus.outValid !== 1'b0) seen = 1'b1;
        end
        checkOutput("midrst_no_stale", 32'(seen), 32'd0);
        checkOutput("midrst_idle_inReady", 32'(bus.inReady), 32'd1);
        applyStimulus(4'b1111, 1'b0, 32'd100, 32'd7, 32'd0, 1'b0);
        checkOutput("post_rst_remu", gotRes, 32'd2);

        // 16-bit instance: basic scenario plus carry boundary.
        apply16(4'b0000, 1'b0, 16'd3, 16'd5, 16'd0);
        checkOutput("w16_add_res",  32'(got16Res),  32'd8);
        checkOutput("w16_add_ovf",  32'(got16Ovf),  32'd0);
        checkOutput("w16_add_zero", 32'(got16Zero), 32'd0);
        checkOutput("w16_add_lat",  32'(got16Lat),  32'd1);
        apply16(4'b0000, 1'b1, 16'd7, 16'd100, 16'd9);
        checkOutput("w16_addimm_res", 32'(got16Res), 32'd16);
        apply16(4'b0000, 1'b0, 16'hFFFF, 16'd1, 16'd0);
        checkOutput("w16_carry_res",  32'(got16Res),  32'd0);
        checkOutput("w16_carry_ovf",  32'(got16Ovf),  32'd1);
        checkOutput("w16_carry_zero", 32'(got16Zero), 32'd1);
        apply16(4'b1101, 1'b0, 16'h0100, 16'h0300, 16'd0);
        checkOutput("w16_mulhu_res", 32'(got16Res), 32'd3);
        checkOutput("w16_mulhu_lat", 32'(got16Lat), 32'd17);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
